// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter and its scoreboard:
// register-file geometry and the arbitration source selector.
package wb_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    // Which source, if any, owns the writeback port this cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2
    } src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard. Each architectural register
// 1..15 carries a saturating CNT_W-bit count of issued-but-uncommitted
// writes; register 0 is never tracked. Issue into a full counter is
// refused through issue_stall, and a commit against an empty counter is
// recorded in the sticky wb_err flag.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    output logic                  issue_stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                wb_err_q;
    logic                wb_err_d;
    logic                inc_en;
    logic                dec_en;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    // A full counter cannot accept another outstanding write
    assign issue_stall = issue_valid && (cnt_q[issue_rd] == CNT_MAX);

    // Writes to R0 are architecturally discarded, so they never count
    assign inc_en  = issue_valid && !issue_stall && (issue_rd != '0);
    assign dec_en  = commit_valid && (commit_rd != '0);
    assign inc_vec = inc_en ? (NUM_REGS'(1) << issue_rd)  : '0;
    assign dec_vec = dec_en ? (NUM_REGS'(1) << commit_rd) : '0;

    // Next counter values; a same-register issue and commit cancel out
    always_comb begin
        cnt_d    = cnt_q;
        wb_err_d = wb_err_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) begin
                    wb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // Busy mirrors a non-zero pending count; R0 is hard-wired idle
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    // Counter and error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err = wb_err_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results onto a single register
// file write port with one cycle of registered latency. Loads normally
// win, but an ALU result denied STARVE_LIMIT cycles in a row is forced
// through. Optional result forwarding is built when WB_FORWARD_EN is
// defined; otherwise the forwarding outputs are constant zero.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [REG_W-1:0]      alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_W-1:0]      mem_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic [REG_ADDR_W-1:0] write_Rd,
    output logic [REG_W-1:0]      write_data,
    output logic                  wb_err,
    input  logic [REG_ADDR_W-1:0] fwd_Ra,
    input  logic [REG_ADDR_W-1:0] fwd_Rb,
    output logic                  fwd_hit_a,
    output logic                  fwd_hit_b,
    output logic [REG_W-1:0]      fwd_data_a,
    output logic [REG_W-1:0]      fwd_data_b
);

    localparam int               STV_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    src_e                  sel;
    logic [STV_W-1:0]      starve_q;
    logic [STV_W-1:0]      starve_d;
    logic [REG_ADDR_W-1:0] write_rd_q;
    logic [REG_ADDR_W-1:0] write_rd_d;
    logic [REG_W-1:0]      write_data_q;
    logic [REG_W-1:0]      write_data_d;

    // Grant at most one valid source; nothing is granted while in reset
    always_comb begin
        sel = SRC_NONE;
        if (!rst_n) begin
            sel = SRC_NONE;
        end else if (alu_valid && mem_valid) begin
            sel = (starve_q == STV_MAX) ? SRC_ALU : SRC_MEM;
        end else if (alu_valid) begin
            sel = SRC_ALU;
        end else if (mem_valid) begin
            sel = SRC_MEM;
        end
    end

    assign alu_ready = (sel == SRC_ALU);
    assign mem_ready = (sel == SRC_MEM);

    // Granted result for the output register; idle cycles write R0 with 0
    always_comb begin
        write_rd_d   = '0;
        write_data_d = '0;
        case (sel)
            SRC_ALU: begin
                write_rd_d   = alu_rd;
                write_data_d = alu_data;
            end
            SRC_MEM: begin
                write_rd_d   = mem_rd;
                write_data_d = mem_data;
            end
            default: begin
                write_rd_d   = '0;
                write_data_d = '0;
            end
        endcase
    end

    // Count consecutive denied ALU cycles, saturating at the forcing limit
    always_comb begin
        starve_d = '0;
        if (alu_valid && (sel != SRC_ALU)) begin
            starve_d = (starve_q == STV_MAX) ? starve_q : starve_q + 1'b1;
        end
    end

    // Output register and starvation state; reset drops any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_rd_q   <= '0;
            write_data_q <= '0;
            starve_q     <= '0;
        end else begin
            write_rd_q   <= write_rd_d;
            write_data_q <= write_data_d;
            starve_q     <= starve_d;
        end
    end

    assign write_Rd   = write_rd_q;
    assign write_data = write_data_q;

    // Pending counts retire at grant time, not when the write lands
    wb_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .commit_valid (sel != SRC_NONE),
        .commit_rd    (write_rd_d),
        .issue_stall  (issue_stall),
        .busy         (busy),
        .wb_err       (wb_err)
    );

`ifdef WB_FORWARD_EN
    // Forward the result currently on the write port; R0 never forwards
    assign fwd_hit_a  = (fwd_Ra == write_rd_q) && (write_rd_q != '0);
    assign fwd_hit_b  = (fwd_Rb == write_rd_q) && (write_rd_q != '0);
    assign fwd_data_a = fwd_hit_a ? write_data_q : '0;
    assign fwd_data_b = fwd_hit_b ? write_data_q : '0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_Ra, fwd_Rb};
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_data_b = '0;
`endif

endmodule
